f15_cfg_ctrl: RTL and testbench
===============================

F15_CFG_CTRL -- requirements
Module: f15_cfg_ctrl

Interface
REQ-001 Parameter SR_BASE, 8'd0, base settings-bus address; the block decodes offsets 0..4 from SR_BASE.
REQ-002 Parameter IDLE_CYCLES, 4096, number of cycles without a frame boundary before pending updates are forced.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 set_stb  in  1  settings write strobe, one cycle per write.
REQ-006 set_addr  in  8  settings write address.
REQ-007 set_data  in  32  settings write data.
REQ-008 frame_end  in  1  one-cycle pulse on the last input sample of a frame (i_tvalid & i_tready & i_tlast of the datapath).
REQ-009 rb_addr  in  3  readback select.
REQ-010 rb_data  out  32  registered readback data.
REQ-011 cfg_random  out  2;  cfg_offset, cfg_scale, cfg_trise, cfg_tdecay, cfg_alpha, cfg_epsilon  out  16 each;  cfg_decim  out  12; all are active datapath configuration.
REQ-012 cfg_decim_changed  out  1  one-cycle pulse when active cfg_decim changes value.
REQ-013 clear_req  out  1  one-cycle histogram/average clear request.
REQ-014 pending  out  1  high while shadow values or a clear await commit.

Function
REQ-015 Register map (offset: fields): 0 CTRL: [0] clear (write-1, self-clearing), [2:1] random; 1 DECIM: [11:0]; 2: [15:0] offset, [31:16] scale; 3: [15:0] trise, [31:16] tdecay; 4: [15:0] alpha, [31:16] epsilon.
REQ-016 A write with set_stb=1 and set_addr in SR_BASE..SR_BASE+4 SHALL update the shadow register on the next edge and set the pending flag; writes to other addresses SHALL be ignored.
REQ-017 Active cfg_* outputs SHALL change only on a commit cycle, never directly from a write.
REQ-018 Commit SHALL occur on the edge following frame_end=1 while pending=1, copying all shadow values to active outputs and clearing pending.
REQ-019 Idle counter SHALL increment each cycle while pending=1 and frame_end=0, reset to 0 on frame_end or commit; when it reaches IDLE_CYCLES-1 a commit SHALL occur on the next edge.
REQ-020 A write in the same cycle as a commit trigger SHALL NOT be included in that commit; its shadow is updated and pending SHALL remain 1 (set wins over clear).
REQ-021 A CTRL write with bit0=1 SHALL set a clear-pending bit; on commit clear_req SHALL pulse high for exactly one cycle, aligned with the updated cfg_* outputs.
REQ-022 cfg_decim_changed SHALL pulse one cycle on a commit whose new decim differs from the old active decim; no pulse when equal.
REQ-023 Multiple writes before a commit SHALL coalesce; last value per field wins; multiple clear writes yield a single clear_req pulse.
REQ-024 rb_data SHALL be registered one cycle after rb_addr: offsets 0..4 return active values in register-map layout (CTRL bit0 reads 0); offset 5 returns {31'd0, pending}; offsets 6..7 return 0.

Reset
REQ-025 On reset: shadow and active offset=0, scale=16'h0100, trise=16'h1000, tdecay=16'h1000, alpha=16'h1000, epsilon=16'h0001, decim=12'd2, random=2'b00.
REQ-026 On reset: pending=0, clear-pending=0, idle counter=0, clear_req=0, cfg_decim_changed=0, rb_data=0.
REQ-027 Reset asserted mid-pending SHALL discard all uncommitted writes and any pending clear.

Structure
REQ-028 Register offsets, field positions and reset values SHALL live in a shared package f15_cfg_pkg.
REQ-029 The block SHALL be a single module with no sub-modules.

Verification
REQ-030 Write offset 2 = 32'h0200_0010, no frame_end -> cfg_offset stays 0, pending=1; pulse frame_end -> next cycle cfg_offset=16'h0010, cfg_scale=16'h0200, pending=0.
REQ-031 Write DECIM=12'd8 and CTRL=32'h1, pulse frame_end -> single-cycle clear_req and cfg_decim_changed together, cfg_decim=8; re-write DECIM=8 and commit -> no cfg_decim_changed.
REQ-032 IDLE_CYCLES=16, write offset 3 = 32'h0000_0200, no frame_end -> cfg_trise=16'h0200 exactly 16 cycles after the write lands, pending=0.
REQ-033 Write offset 4 in the same cycle as frame_end -> commit excludes it, pending stays 1; next frame_end -> cfg_alpha updated.
REQ-034 Write offset 1 then assert reset before frame_end -> cfg_decim=2, pending=0, no pulses after reset release and frame_end.
REQ-035 rb_addr=5 with pending=1 -> rb_data=32'h1 one cycle later; rb_addr=2 after REQ-030 commit -> rb_data=32'h0200_0010.

Source files
------------

// File: rtl/f15_cfg_pkg.sv
// Shared register map, field layout and reset values for the f15 settings controller.
// Both the controller and anything decoding its readback import this package.
package f15_cfg_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_DECIM  = 3'd1,
    REG_GAIN   = 3'd2,
    REG_TIME   = 3'd3,
    REG_ADAPT  = 3'd4,
    REG_STATUS = 3'd5
  } reg_off_e;

  localparam int NUM_WR_REGS    = 5;
  localparam int CTRL_CLEAR_BIT = 0;
  localparam int DECIM_W        = 12;

  typedef struct packed {
    logic [1:0]         random;
    logic [DECIM_W-1:0] decim;
    logic [15:0]        offset;
    logic [15:0]        scale;
    logic [15:0]        trise;
    logic [15:0]        tdecay;
    logic [15:0]        alpha;
    logic [15:0]        epsilon;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    random:  2'b00,
    decim:   12'd2,
    offset:  16'h0000,
    scale:   16'h0100,
    trise:   16'h1000,
    tdecay:  16'h1000,
    alpha:   16'h1000,
    epsilon: 16'h0001
  };

  // Apply one settings-bus write to a configuration set; unmapped offsets leave it untouched.
  function automatic cfg_t cfg_write(input cfg_t c, input logic [2:0] off,
                                     input logic [31:0] d);
    cfg_t r;
    r = c;
    case (off)
      REG_CTRL:  r.random = d[2:1];
      REG_DECIM: r.decim  = d[DECIM_W-1:0];
      REG_GAIN: begin
        r.offset = d[15:0];
        r.scale  = d[31:16];
      end
      REG_TIME: begin
        r.trise  = d[15:0];
        r.tdecay = d[31:16];
      end
      REG_ADAPT: begin
        r.alpha   = d[15:0];
        r.epsilon = d[31:16];
      end
      default: ;
    endcase
    return r;
  endfunction

  // Register-map view of a configuration set; the clear bit is write-only and reads 0.
  function automatic logic [31:0] cfg_readback(input cfg_t c, input logic [2:0] off,
                                               input logic pend);
    logic [31:0] w;
    w = '0;
    case (off)
      REG_CTRL:   w[2:1] = c.random;
      REG_DECIM:  w[DECIM_W-1:0] = c.decim;
      REG_GAIN:   w = {c.scale, c.offset};
      REG_TIME:   w = {c.tdecay, c.trise};
      REG_ADAPT:  w = {c.epsilon, c.alpha};
      REG_STATUS: w[0] = pend;
      default:    w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/f15_cfg_ctrl.sv
// Settings-bus controller: writes land in shadow registers and are committed to the
// active datapath configuration only at a frame boundary or after an idle timeout.
module f15_cfg_ctrl
  import f15_cfg_pkg::*;
#(
  parameter logic [7:0] SR_BASE     = 8'd0,
  parameter int         IDLE_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        frame_end,
  input  logic [2:0]  rb_addr,
  output logic [31:0] rb_data,
  output logic [1:0]  cfg_random,
  output logic [15:0] cfg_offset,
  output logic [15:0] cfg_scale,
  output logic [15:0] cfg_trise,
  output logic [15:0] cfg_tdecay,
  output logic [15:0] cfg_alpha,
  output logic [15:0] cfg_epsilon,
  output logic [11:0] cfg_decim,
  output logic        cfg_decim_changed,
  output logic        clear_req,
  output logic        pending
);

  localparam int            CW        = $clog2(IDLE_CYCLES) + 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  cfg_t          shadow;
  cfg_t          shadow_nxt;
  cfg_t          active;
  logic          clr_pend;
  logic [CW-1:0] idle_cnt;

  logic [7:0]    wr_off;
  logic          wr_hit;
  logic          clr_write;
  logic          commit;

  // Offset relative to the base; anything at or beyond NUM_WR_REGS (incl. wraparound) is ignored.
  assign wr_off    = set_addr - SR_BASE;
  assign wr_hit    = set_stb && (wr_off < 8'(NUM_WR_REGS));
  assign clr_write = wr_hit && (wr_off[2:0] == REG_CTRL) && set_data[CTRL_CLEAR_BIT];
  assign commit    = pending && (frame_end || (idle_cnt == IDLE_LAST));

  always_comb begin
    shadow_nxt = shadow;
    if (wr_hit) begin
      shadow_nxt = cfg_write(shadow, wr_off[2:0], set_data);
    end
  end

  // Active takes the pre-write shadow, so a write coincident with a commit waits for the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow            <= CFG_RESET;
      active            <= CFG_RESET;
      pending           <= 1'b0;
      clr_pend          <= 1'b0;
      idle_cnt          <= '0;
      clear_req         <= 1'b0;
      cfg_decim_changed <= 1'b0;
      rb_data           <= '0;
    end else begin
      shadow            <= shadow_nxt;
      clear_req         <= commit && clr_pend;
      cfg_decim_changed <= commit && (shadow.decim != active.decim);
      if (commit) begin
        active <= shadow;
      end
      pending  <= wr_hit || (pending && !commit);
      clr_pend <= clr_write || (clr_pend && !commit);
      if (commit || frame_end) begin
        idle_cnt <= '0;
      end else if (pending) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
      rb_data <= cfg_readback(active, rb_addr, pending);
    end
  end

  assign cfg_random  = active.random;
  assign cfg_decim   = active.decim;
  assign cfg_offset  = active.offset;
  assign cfg_scale   = active.scale;
  assign cfg_trise   = active.trise;
  assign cfg_tdecay  = active.tdecay;
  assign cfg_alpha   = active.alpha;
  assign cfg_epsilon = active.epsilon;

endmodule

// File: tb/tb_f15_cfg_ctrl.sv
// Bench for f15_cfg_ctrl: hand sequences for commit timing corners, then a vector table
// of register writes checked on the cfg_* outputs and through the readback port.
module tb_f15_cfg_ctrl;

  localparam logic [7:0] BASE = 8'h40;
  localparam int         IDLE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        frame_end = 1'b0;
  logic [2:0]  rb_addr = '0;
  logic [31:0] rb_data;
  logic [1:0]  cfg_random;
  logic [15:0] cfg_offset, cfg_scale, cfg_trise, cfg_tdecay, cfg_alpha, cfg_epsilon;
  logic [11:0] cfg_decim;
  logic        cfg_decim_changed, clear_req, pending;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  f15_cfg_ctrl #(.SR_BASE(BASE), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .frame_end(frame_end), .rb_addr(rb_addr), .rb_data(rb_data), .cfg_random(cfg_random),
    .cfg_offset(cfg_offset), .cfg_scale(cfg_scale), .cfg_trise(cfg_trise),
    .cfg_tdecay(cfg_tdecay), .cfg_alpha(cfg_alpha), .cfg_epsilon(cfg_epsilon),
    .cfg_decim(cfg_decim), .cfg_decim_changed(cfg_decim_changed), .clear_req(clear_req),
    .pending(pending)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic fe();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rb_check(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] e;
    rb_addr = a;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got empty queue expected entry", nm);
    end else begin
      e = exp_q.pop_front();
      check(nm, rb_data, e);
    end
  endtask

  function automatic logic [31:0] dut_word(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, cfg_random, 1'b0};
      3'd1:    return {20'd0, cfg_decim};
      3'd2:    return {cfg_scale, cfg_offset};
      3'd3:    return {cfg_tdecay, cfg_trise};
      3'd4:    return {cfg_epsilon, cfg_alpha};
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] exp_rb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;

    vecs[0] = '{3'd0, 32'hFFFF_FFF4, 32'h0000_0004};
    vecs[1] = '{3'd0, 32'h0000_0003, 32'h0000_0002};
    vecs[2] = '{3'd1, 32'hFFFF_F123, 32'h0000_0123};
    vecs[3] = '{3'd1, 32'h0000_0FFF, 32'h0000_0FFF};
    vecs[4] = '{3'd2, 32'hABCD_1234, 32'hABCD_1234};
    vecs[5] = '{3'd3, 32'h8000_0001, 32'h8000_0001};
    vecs[6] = '{3'd4, 32'h1234_FFFF, 32'h1234_FFFF};
    vecs[7] = '{3'd2, 32'h0000_0000, 32'h0000_0000};

    // ---- reset state ----
    tick();
    tick();
    check("rst_offset", 32'(cfg_offset), 32'h0000);
    check("rst_scale", 32'(cfg_scale), 32'h0100);
    check("rst_trise", 32'(cfg_trise), 32'h1000);
    check("rst_tdecay", 32'(cfg_tdecay), 32'h1000);
    check("rst_alpha", 32'(cfg_alpha), 32'h1000);
    check("rst_epsilon", 32'(cfg_epsilon), 32'h0001);
    check("rst_decim", 32'(cfg_decim), 32'd2);
    check("rst_random", 32'(cfg_random), 32'd0);
    check("rst_flags", {29'd0, pending, clear_req, cfg_decim_changed}, 32'd0);
    check("rst_rb_data", rb_data, 32'd0);
    reset = 1'b0;
    tick();

    // ---- write held in shadow until frame_end ----
    wr(BASE + 8'd2, 32'h0200_0010);
    check("shadow_offset_held", 32'(cfg_offset), 32'h0000);
    check("shadow_pending", 32'(pending), 32'd1);
    tick();
    tick();
    check("shadow_offset_still", 32'(cfg_offset), 32'h0000);
    rb_check("rb_status_pending", 3'd5, 32'h1);
    fe();
    check("commit_offset", 32'(cfg_offset), 32'h0010);
    check("commit_scale", 32'(cfg_scale), 32'h0200);
    check("commit_pending", 32'(pending), 32'd0);
    rb_check("rb_gain", 3'd2, 32'h0200_0010);
    rb_check("rb_status_idle", 3'd5, 32'h0);
    rb_check("rb_unmapped6", 3'd6, 32'h0);
    rb_check("rb_unmapped7", 3'd7, 32'h0);

    // ---- clear + decim change pulse together ----
    wr(BASE + 8'd1, 32'd8);
    wr(BASE + 8'd0, 32'h1);
    fe();
    check("clr_pulse", 32'(clear_req), 32'd1);
    check("decim_chg_pulse", 32'(cfg_decim_changed), 32'd1);
    check("decim_8", 32'(cfg_decim), 32'd8);
    tick();
    check("clr_pulse_end", {30'd0, clear_req, cfg_decim_changed}, 32'd0);
    wr(BASE + 8'd1, 32'd8);
    fe();
    check("decim_same_no_chg", {30'd0, clear_req, cfg_decim_changed}, 32'd0);
    check("decim_same_val", 32'(cfg_decim), 32'd8);

    // ---- coalescing ----
    wr(BASE + 8'd0, 32'h1);
    wr(BASE + 8'd0, 32'h1);
    wr(BASE + 8'd1, 32'd5);
    wr(BASE + 8'd1, 32'd9);
    fe();
    check("coal_clr", 32'(clear_req), 32'd1);
    check("coal_decim", 32'(cfg_decim), 32'd9);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (clear_req) pulses++;
    end
    check("coal_single_clr", 32'(pulses), 32'd0);

    // ---- out-of-range writes and frame_end without pending ----
    wr(BASE + 8'd5, 32'hFFFF_FFFF);
    wr(BASE - 8'd1, 32'hFFFF_FFFF);
    check("oor_no_pending", 32'(pending), 32'd0);
    fe();
    check("oor_no_commit", {cfg_decim, 19'd0, clear_req}, {12'd9, 20'd0});

    // ---- idle timeout commit ----
    wr(BASE + 8'd3, 32'h0000_0200);
    for (int i = 1; i < IDLE; i++) tick();
    check("idle_before", 32'(cfg_trise), 32'h1000);
    check("idle_before_pend", 32'(pending), 32'd1);
    tick();
    check("idle_trise", 32'(cfg_trise), 32'h0200);
    check("idle_tdecay", 32'(cfg_tdecay), 32'h0000);
    check("idle_pending", 32'(pending), 32'd0);

    // ---- write coincident with commit trigger ----
    wr(BASE + 8'd3, 32'h0011_0777);
    set_stb   = 1'b1;
    set_addr  = BASE + 8'd4;
    set_data  = 32'h0003_0500;
    frame_end = 1'b1;
    tick();
    set_stb   = 1'b0;
    frame_end = 1'b0;
    check("coinc_trise", 32'(cfg_trise), 32'h0777);
    check("coinc_alpha_old", 32'(cfg_alpha), 32'h1000);
    check("coinc_pending", 32'(pending), 32'd1);
    fe();
    check("coinc_alpha_new", {cfg_epsilon, cfg_alpha}, 32'h0003_0500);
    check("coinc_pending_clr", 32'(pending), 32'd0);

    // ---- table-driven register vectors ----
    for (int i = 0; i < 8; i++) begin
      wr(BASE + 8'(vecs[i].off), vecs[i].data);
      fe();
      check($sformatf("vec%0d_out", i), dut_word(vecs[i].off), vecs[i].exp_rb);
      rb_check($sformatf("vec%0d_rb", i), vecs[i].off, vecs[i].exp_rb);
    end

    // ---- reset mid-pending discards writes and clear ----
    wr(BASE + 8'd1, 32'd7);
    wr(BASE + 8'd0, 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_decim", 32'(cfg_decim), 32'd2);
    check("midrst_pending", 32'(pending), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    fe();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (clear_req || cfg_decim_changed) pulses++;
      tick();
    end
    check("postrst_no_pulse", 32'(pulses), 32'd0);
    check("postrst_decim", 32'(cfg_decim), 32'd2);
    check("postrst_pending", 32'(pending), 32'd0);

    // ---- final report ----
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
